// File: rtl/multi_axis_reflex_ctrl.sv
// multi_axis_reflex_ctrl
//   N_CH-channel PID + reflex-NN blended controller. The channels share one
//   arithmetic path and are processed in sequence, two cycles per channel.
//   CALC_A computes the error, integrator and derivative terms.
//   CALC_B computes the PID and NN terms and the blended thrust output.
//   Optional build macro: SLEW_LIMIT_EN. It adds the SLEW_MAX parameter,
//   which limits the per-sample change of every thrust channel.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   sample_valid/ready input sample handshake (ready = idle)
//   pos_cur, pos_tgt, vel, acc   packed signed per-channel inputs, DW each
//   cfg_we/ch/sel/data  gain write (sel 0=kp 1=ki 2=kd 3=compliance[7:0])
//   cfg_err           one-cycle pulse when a config write is rejected
//   integ_clr         clear integrators, last error and saturation history
//   out_valid/ready   thrust vector handshake
//   thrust            packed signed per-channel thrust, DW each
//   sat_flags         per-channel PID clamp hit on the last sample
module multi_axis_reflex_ctrl #(
  parameter int N_CH    = 4,
  parameter int DW      = 16,
  parameter int OUT_LIM = 1000,
  parameter int INT_LIM = 32767,
  parameter int CHW     = (N_CH > 1) ? $clog2(N_CH) : 1
`ifdef SLEW_LIMIT_EN
  ,
  parameter int SLEW_MAX = 50
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_valid,
  output logic               sample_ready,
  input  logic [N_CH*DW-1:0] pos_cur,
  input  logic [N_CH*DW-1:0] pos_tgt,
  input  logic [N_CH*DW-1:0] vel,
  input  logic [N_CH*DW-1:0] acc,
  input  logic               cfg_we,
  input  logic [CHW-1:0]     cfg_ch,
  input  logic [1:0]         cfg_sel,
  input  logic [DW-1:0]      cfg_data,
  output logic               cfg_err,
  input  logic               integ_clr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N_CH*DW-1:0] thrust,
  output logic [N_CH-1:0]    sat_flags
);

  localparam int W = 2*DW + 8;
  localparam logic [1:0] IDLE = 2'd0, CALC_A = 2'd1, CALC_B = 2'd2, DONE = 2'd3;
  localparam logic signed [W-1:0] OUT_MAX = W'(OUT_LIM);
  localparam logic signed [W-1:0] INT_MAX = W'(INT_LIM);
  localparam logic signed [W-1:0] NN_MAX  = W'(500);

  function automatic logic signed [W-1:0] clamp(input logic signed [W-1:0] v,
                                                 input logic signed [W-1:0] lim);
    if (v > lim) return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

  function automatic logic signed [W-1:0] sx(input logic signed [DW:0] v);
    return {{(W-DW-1){v[DW]}}, v};
  endfunction

  logic [1:0]            state_q, state_d;
  logic [CHW-1:0]        ch_q, ch_d;
  logic [N_CH*DW-1:0]    cur_q, cur_d, tgt_q, tgt_d, vel_q, vel_d, acc_q, acc_d;
  logic [N_CH*DW-1:0]    thrust_q, thrust_d;
  logic signed [DW-1:0]  kp_q [N_CH], kp_d [N_CH], ki_q [N_CH], ki_d [N_CH];
  logic signed [DW-1:0]  kd_q [N_CH], kd_d [N_CH], le_q [N_CH], le_d [N_CH];
  logic [7:0]            comp_q [N_CH], comp_d [N_CH];
  logic signed [W-1:0]   integ_q [N_CH], integ_d [N_CH];
  logic [N_CH-1:0]       sat_q, sat_d, psat_q, psat_d, pneg_q, pneg_d;
  logic signed [DW-1:0]  err_q, err_d;
  logic signed [DW:0]    deriv_q, deriv_d;
  logic                  cfg_err_q, cfg_err_d, clr_pend_q, clr_pend_d;

  logic signed [DW-1:0]  s_cur, s_tgt, s_vel, s_acc, s_kp, s_ki, s_kd, s_le;
  logic [7:0]            s_c;
  logic signed [W-1:0]   s_integ;
  logic                  s_psat, s_pneg, do_clr, sat;
  logic signed [DW:0]    err_ext, deriv;
  logic signed [DW-1:0]  err_sat;
  logic signed [W-1:0]   integ_new, p, i, d, pid_raw, pid, l1, nn, cw, mix;
`ifdef SLEW_LIMIT_EN
  logic signed [DW-1:0]  s_thr;
  logic signed [W-1:0]   prev;
`endif

  always_comb begin
    state_d = state_q;  ch_d = ch_q;
    cur_d = cur_q;  tgt_d = tgt_q;  vel_d = vel_q;  acc_d = acc_q;
    thrust_d = thrust_q;
    kp_d = kp_q;  ki_d = ki_q;  kd_d = kd_q;  comp_d = comp_q;
    integ_d = integ_q;  le_d = le_q;
    sat_d = sat_q;  psat_d = psat_q;  pneg_d = pneg_q;
    err_d = err_q;  deriv_d = deriv_q;
    cfg_err_d = 1'b0;  clr_pend_d = clr_pend_q;  do_clr = 1'b0;

    // Operand select for the channel currently in the shared datapath.
    s_cur = '0;  s_tgt = '0;  s_vel = '0;  s_acc = '0;
    s_kp = '0;  s_ki = '0;  s_kd = '0;  s_le = '0;  s_c = '0;  s_integ = '0;
    s_psat = 1'b0;  s_pneg = 1'b0;
`ifdef SLEW_LIMIT_EN
    s_thr = '0;
`endif
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (32'(ch_q) == k) begin
        s_cur = cur_q[k*DW +: DW];  s_tgt = tgt_q[k*DW +: DW];
        s_vel = vel_q[k*DW +: DW];  s_acc = acc_q[k*DW +: DW];
        s_kp = kp_q[k];  s_ki = ki_q[k];  s_kd = kd_q[k];  s_le = le_q[k];
        s_c = comp_q[k];  s_integ = integ_q[k];
        s_psat = psat_q[k];  s_pneg = pneg_q[k];
`ifdef SLEW_LIMIT_EN
        s_thr = thrust_q[k*DW +: DW];
`endif
      end
    end

    // CALC_A datapath
    err_ext = {s_tgt[DW-1], s_tgt} - {s_cur[DW-1], s_cur};
    if (err_ext[DW] != err_ext[DW-1])
      err_sat = err_ext[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    else
      err_sat = err_ext[DW-1:0];
    // Anti-windup: hold while saturated and the error still pushes the same way.
    if (s_psat && (err_sat[DW-1] == s_pneg))
      integ_new = s_integ;
    else
      integ_new = clamp(s_integ + sx({err_sat[DW-1], err_sat}), INT_MAX);
    deriv = {err_sat[DW-1], err_sat} - {s_le[DW-1], s_le};

    // CALC_B datapath (err/deriv registered, integrator already updated)
    p = (sx({err_q[DW-1], err_q}) * sx({s_kp[DW-1], s_kp})) >>> 8;
    i = (s_integ * sx({s_ki[DW-1], s_ki})) >>> 16;
    d = (sx(deriv_q) * sx({s_kd[DW-1], s_kd})) >>> 8;
    pid_raw = p + i + d;
    pid = clamp(pid_raw, OUT_MAX);
    sat = (pid != pid_raw);
    l1 = clamp(((sx({err_q[DW-1], err_q}) >>> 2) * 16)
             + ((sx({s_vel[DW-1], s_vel}) >>> 4) * 8)
             + ((sx({s_acc[DW-1], s_acc}) >>> 6) * 4), NN_MAX);
    nn = (l1 * 80) >>> 7;
    cw = {{(W-8){1'b0}}, s_c};
    mix = clamp(((pid * (255 - cw)) + (nn * cw)) >>> 8, OUT_MAX);
`ifdef SLEW_LIMIT_EN
    prev = sx({s_thr[DW-1], s_thr});
    if (mix > prev + W'(SLEW_MAX)) mix = prev + W'(SLEW_MAX);
    else if (mix < prev - W'(SLEW_MAX)) mix = prev - W'(SLEW_MAX);
`endif

    if (cfg_we && state_q != IDLE) cfg_err_d = 1'b1;
    if (integ_clr && state_q != IDLE) clr_pend_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (cfg_we) begin
          if (32'(cfg_ch) < N_CH) begin
            for (int unsigned k = 0; k < N_CH; k++) begin
              if (32'(cfg_ch) == k) begin
                case (cfg_sel)
                  2'd0: kp_d[k] = cfg_data;
                  2'd1: ki_d[k] = cfg_data;
                  2'd2: kd_d[k] = cfg_data;
                  default: comp_d[k] = cfg_data[7:0];
                endcase
              end
            end
          end else begin
            cfg_err_d = 1'b1;
          end
        end
        if (integ_clr) do_clr = 1'b1;
        if (sample_valid) begin
          cur_d = pos_cur;  tgt_d = pos_tgt;  vel_d = vel;  acc_d = acc;
          ch_d = '0;
          state_d = CALC_A;
        end
      end
      CALC_A: begin
        for (int unsigned k = 0; k < N_CH; k++) begin
          if (32'(ch_q) == k) begin
            integ_d[k] = integ_new;
            le_d[k] = err_sat;
          end
        end
        err_d = err_sat;
        deriv_d = deriv;
        state_d = CALC_B;
      end
      CALC_B: begin
        for (int unsigned k = 0; k < N_CH; k++) begin
          if (32'(ch_q) == k) begin
            thrust_d[k*DW +: DW] = DW'(mix);
            sat_d[k] = sat;
            psat_d[k] = sat;
            pneg_d[k] = pid[W-1];
          end
        end
        if (32'(ch_q) == N_CH - 1) state_d = DONE;
        else begin
          ch_d = ch_q + CHW'(1);
          state_d = CALC_A;
        end
      end
      default: begin
        if (out_ready) begin
          state_d = IDLE;
          // A clear requested during this very cycle is folded in here too.
          if (clr_pend_q || integ_clr) begin
            do_clr = 1'b1;
            clr_pend_d = 1'b0;
          end
        end
      end
    endcase

    if (do_clr) begin
      for (int unsigned k = 0; k < N_CH; k++) begin
        integ_d[k] = '0;
        le_d[k] = '0;
      end
      psat_d = '0;
      pneg_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;  ch_q <= '0;
      cur_q <= '0;  tgt_q <= '0;  vel_q <= '0;  acc_q <= '0;  thrust_q <= '0;
      for (int unsigned k = 0; k < N_CH; k++) begin
        kp_q[k] <= DW'(256);  ki_q[k] <= '0;  kd_q[k] <= '0;  comp_q[k] <= '0;
        integ_q[k] <= '0;  le_q[k] <= '0;
      end
      sat_q <= '0;  psat_q <= '0;  pneg_q <= '0;
      err_q <= '0;  deriv_q <= '0;  cfg_err_q <= 1'b0;  clr_pend_q <= 1'b0;
    end else begin
      state_q <= state_d;  ch_q <= ch_d;
      cur_q <= cur_d;  tgt_q <= tgt_d;  vel_q <= vel_d;  acc_q <= acc_d;
      thrust_q <= thrust_d;
      kp_q <= kp_d;  ki_q <= ki_d;  kd_q <= kd_d;  comp_q <= comp_d;
      integ_q <= integ_d;  le_q <= le_d;
      sat_q <= sat_d;  psat_q <= psat_d;  pneg_q <= pneg_d;
      err_q <= err_d;  deriv_q <= deriv_d;
      cfg_err_q <= cfg_err_d;  clr_pend_q <= clr_pend_d;
    end
  end

  assign sample_ready = (state_q == IDLE);
  assign out_valid    = (state_q == DONE);
  assign thrust       = thrust_q;
  assign sat_flags    = sat_q;
  assign cfg_err      = cfg_err_q;

endmodule

// File: doc/multi_axis_reflex_ctrl.md
Name: multi_axis_reflex_ctrl

Overview:
Parametrised successor to the single-axis altitude reflex controller. Runs N_CH independent PID + reflex-NN blended control channels (altitude, roll, pitch, yaw, …) through one time-multiplexed arithmetic path. Adds per-channel runtime-writable gains, conditional-integration anti-windup, valid/ready handshakes and saturation flags. Sits between the sensor-fusion front end and the thrust mixer.

Parameters:
N_CH, 4, number of control channels (1..16)
DW, 16, signed data width of sensor, target and output samples
OUT_LIM, 1000, symmetric output clamp magnitude
INT_LIM, 32767, symmetric integrator clamp magnitude
CHW, max(1,clog2(N_CH)), channel index width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
sample_valid  in  1  input sample set valid
sample_ready  out  1  block idle, can accept a sample
pos_cur  in  N_CH*DW  packed signed current position per channel
pos_tgt  in  N_CH*DW  packed signed target per channel
vel  in  N_CH*DW  packed signed velocity per channel
acc  in  N_CH*DW  packed signed acceleration per channel
cfg_we  in  1  config write strobe
cfg_ch  in  CHW  config channel index
cfg_sel  in  2  0=kp, 1=ki, 2=kd, 3=compliance (low 8 bits)
cfg_data  in  DW  config value
cfg_err  out  1  one-cycle pulse: write rejected
integ_clr  in  1  clear all integrators
out_valid  out  1  thrust vector valid
out_ready  in  1  downstream accepts thrust vector
thrust  out  N_CH*DW  packed signed thrust per channel
sat_flags  out  N_CH  per-channel PID-stage saturation of the last sample

Behaviour:
- Reset (async, rst=1): state IDLE; thrust=0, sat_flags=0, out_valid=0, cfg_err=0; integrators, last_error and prev_sat cleared; kp=256, ki=0, kd=0, compliance=0 for every channel. sample_ready=1 once rst deasserts. Reset mid-operation aborts the in-flight sample with no output.
- FSM states: IDLE, CALC_A, CALC_B, DONE.
- IDLE: sample_ready=1. On sample_valid=1, all inputs are latched, ch=0, next state CALC_A.
- CALC_A (channel ch):
  - err = tgt − cur, computed at DW+1 bits and saturated to DW.
  - Integrator: if prev_sat[ch]=1 and err has the same sign as the previous PID output, the integrator is held. Otherwise integ += err, clamped to ±INT_LIM.
  - deriv = err − last_error[ch]; last_error[ch] ← err.
- CALC_B (channel ch):
  - p = (err*kp)>>>8; i = (integ*ki)>>>16; d = (deriv*kd)>>>8, all at 2*DW+8 bits. pid = p+i+d, clamped to ±OUT_LIM; sat = clamp hit.
  - NN: l1 = (err>>>2)*16 + (vel>>>4)*8 + (acc>>>6)*4, clamped to ±500; nn = (l1*80)>>>7.
  - mix = (pid*(255−c) + nn*c)>>>8, clamped to ±OUT_LIM, written to the thrust[ch] slice. sat_flags[ch] and prev_sat[ch] ← sat.
  - If ch=N_CH−1, go to DONE; else ch+1 and go to CALC_A.
- DONE: out_valid=1, held with thrust stable until out_ready=1. That cycle returns to IDLE and out_valid=0. Latency from accept to out_valid = 2*N_CH+1 cycles.
- Config writes:
  - Accepted in IDLE only, taking effect on the next sample.
  - cfg_we outside IDLE, or cfg_ch ≥ N_CH, is dropped and pulses cfg_err the next cycle.
- integ_clr:
  - In IDLE: clears integrators, last_error and prev_sat next cycle.
  - Otherwise: sets a pending flag, applied on the DONE→IDLE transition.
  - integ_clr coincident with sample_valid in IDLE: the clear wins; the sample is still accepted and sees zeroed state.
- thrust is registered and only changes in CALC_B; out_ready in any state other than DONE is ignored.

Optional Feature:
SLEW_LIMIT_EN. When defined, adds parameter SLEW_MAX (default 50). In CALC_B, the final value is additionally limited to thrust_prev[ch] ± SLEW_MAX after the OUT_LIM clamp; slew limiting does not affect sat or the anti-windup condition. When undefined, no slew logic and no SLEW_MAX parameter exist.

Test Plan:
- N_CH=4, ch0 kp=256, c=0, tgt=100, cur=0, others zero → thrust[0]=99, others 0; out_valid rises exactly 9 cycles after accept.
- ch0 c=255, kp=256, err=100, vel=acc=0 → nn=250, thrust[0]=249.
- ch0 kp=256, ki=256, err=2000 for 3 samples, then err=0 → sat_flags[0]=1 on each of the first three, integrator held at 2000, final thrust[0]=6 (not 22).
- cfg_we during CALC_A, and separately cfg_ch=5 with N_CH=4 → cfg_err one-cycle pulse, gains unchanged, output matches pre-write values.
- Hold out_ready=0 for 10 cycles in DONE → thrust stable, sample_ready=0, a new sample_valid is not accepted; integ_clr asserted meanwhile → next sample with err=0, ki=256 gives thrust 0.
- SLEW_LIMIT_EN, SLEW_MAX=50: two identical samples from the first test → thrust[0]=50, then 99.
